// File: rtl/div_multicycle_pkg.sv
// Shared types for the multi-cycle restoring divider.
// The FSM encodings match the pipeline's existing divider states.
package div_multicycle_pkg;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ON   = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_multicycle_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_multicycle_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               dz_o;
  logic               ovf_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dz_o, ovf_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dz_o, ovf_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the outcome into the quotient.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] rem_hi;
  logic           borrow;

  // rem_in < divisor, so after the shift the remainder needs one extra bit
  always_comb begin
    rem_hi  = {rem_in, quo_in[WIDTH-1]};
    borrow  = rem_hi < {1'b0, divisor};
    rem_out = borrow ? rem_hi[WIDTH-1:0] : WIDTH'(rem_hi - {1'b0, divisor});
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end
endmodule

// File: rtl/div_multicycle.sv
// Iterative restoring divider, BPC quotient bits per cycle, with sign fix-up,
// divide-by-zero and MIN/-1 flags. Result is {remainder, quotient}.
module div_multicycle
  import div_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  div_multicycle_if.slave    bus
);
  localparam int ITER  = WIDTH / BPC;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
  logic                 sgn_q, s1_q, s2_q, ovf_pend;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q, dz_q, ovf_q;
  logic                 accept, div_zero, last_iter;
  logic [WIDTH-1:0]     mag1, mag2, quo_fix, rem_fix;
  logic [BPC:0][WIDTH-1:0] rem_c, quo_c;

  assign accept    = bus.start_i && !bus.annul_i;
  assign div_zero  = (bus.opdata2_i == '0);
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  always_comb begin
    mag1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
    quo_fix = (sgn_q && (s1_q ^ s2_q)) ? -quo_q : quo_q;
    rem_fix = (sgn_q && s1_q) ? -rem_q : rem_q;
  end

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[g]),
      .quo_in  (quo_c[g]),
      .divisor (dvs_q),
      .rem_out (rem_c[g+1]),
      .quo_out (quo_c[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_FREE;
    else      state <= state_nxt;
  end

  // annul wins over completion in every non-idle state
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_FREE: if (accept) state_nxt = div_zero ? DIV_END : DIV_ON;
      DIV_ON:   if (bus.annul_i) state_nxt = DIV_FREE;
                else if (last_iter) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = bus.annul_i ? DIV_FREE : DIV_END;
      DIV_END:  if (bus.annul_i || !bus.start_i) state_nxt = DIV_FREE;
      default:  state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      ovf_pend <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: if (accept) begin
          if (div_zero) begin
            result_q <= '0;
            dz_q     <= 1'b1;
            ready_q  <= 1'b1;
          end else begin
            rem_q    <= '0;
            quo_q    <= mag1;
            dvs_q    <= mag2;
            sgn_q    <= bus.signed_div_i;
            s1_q     <= bus.opdata1_i[WIDTH-1];
            s2_q     <= bus.opdata2_i[WIDTH-1];
            ovf_pend <= bus.signed_div_i && (bus.opdata1_i == MIN_VAL) && (bus.opdata2_i == '1);
            cnt      <= '0;
          end
        end
        DIV_ON: begin
          rem_q <= rem_c[BPC];
          quo_q <= quo_c[BPC];
          cnt   <= cnt + 1'b1;
        end
        DIV_FIX: if (!bus.annul_i) begin
          result_q <= {rem_fix, quo_fix};
          ready_q  <= 1'b1;
          ovf_q    <= ovf_pend;
        end
        default: ;
      endcase
      // every return to idle clears the visible outputs on the same edge
      if (state_nxt == DIV_FREE) begin
        result_q <= '0;
        ready_q  <= 1'b0;
        dz_q     <= 1'b0;
        ovf_q    <= 1'b0;
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.dz_o     = dz_q;
  assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_div_multicycle.sv
// Bench: BPC=1/2/4 dividers driven in lockstep, checked against a table and an arithmetic model.
module tb_div_multicycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        sgn, start, annul;
  logic [31:0] op1, op2;

  logic [63:0] res [3];
  logic        rdy [3];
  logic        dzs [3];
  logic        ovs [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    div_multicycle_if #(.WIDTH(32)) bus ();
    assign bus.signed_div_i = sgn;
    assign bus.opdata1_i    = op1;
    assign bus.opdata2_i    = op2;
    assign bus.start_i      = start;
    assign bus.annul_i      = annul;
    div_multicycle #(.WIDTH(32), .BPC(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign res[g] = bus.result_o;
    assign rdy[g] = bus.ready_o;
    assign dzs[g] = bus.dz_o;
    assign ovs[g] = bus.ovf_o;
  end

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] rq;
    bit          dz;
    bit          ovf;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division semantics, 64-bit so MIN/-1 is exact before truncation
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] rq, output bit dz, output bit ovf);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    dz  = (b == 0);
    ovf = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (dz) begin
      rq = '0;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      rq = {r[31:0], q[31:0]};
    end else begin
      uq = a / b;
      ur = a % b;
      rq = {ur, uq};
    end
  endfunction

  function automatic bit all_out_zero();
    bit z = 1'b1;
    for (int d = 0; d < 3; d++)
      if (rdy[d] !== 1'b0 || dzs[d] !== 1'b0 || ovs[d] !== 1'b0 || res[d] !== 64'd0) z = 1'b0;
    return z;
  endfunction

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] erq, input bit edz, input bit eovf, input string tag);
    int          lat [3];
    logic [63:0] got [3];
    bit          gdz [3];
    bit          gov [3];
    bit          done;
    for (int d = 0; d < 3; d++) begin lat[d] = 0; got[d] = '0; gdz[d] = 0; gov[d] = 0; end
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin op1 = ~a; op2 = $urandom; sgn = ~s; end
      done = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (lat[d] == 0 && rdy[d] === 1'b1) begin
          lat[d] = k; got[d] = res[d]; gdz[d] = dzs[d]; gov[d] = ovs[d];
        end
        if (lat[d] == 0) done = 1'b0;
      end
      if (done) break;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s bpc%0d latency", tag, 1 << d), 64'(lat[d]), edz ? 64'd1 : 64'((32 >> d) + 2));
      chk($sformatf("%s bpc%0d result", tag, 1 << d), got[d], erq);
      chk($sformatf("%s bpc%0d dz", tag, 1 << d), 64'(gdz[d]), 64'(edz));
      chk($sformatf("%s bpc%0d ovf", tag, 1 << d), 64'(gov[d]), 64'(eovf));
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s bpc%0d hold", tag, 1 << d), {rdy[d], res[d][62:0]}, {1'b1, erq[62:0]});
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " cleared after stop"}, 64'(all_out_zero()), 64'd1);
  endtask

  initial begin
    bit s;
    logic [31:0] a, b;
    logic [63:0] erq;
    bit edz, eovf;
    bit seen;

    tbl[0]  = '{0, 32'd100,        32'd7,          {32'd2, 32'd14},                 0, 0};
    tbl[1]  = '{1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  0, 0};
    tbl[2]  = '{0, 32'hFFFF_FFF9,  32'd2,          {32'd1, 32'h7FFF_FFFC},          0, 0};
    tbl[3]  = '{1, 32'd100,        32'd0,          64'd0,                           1, 0};
    tbl[4]  = '{0, 32'd100,        32'd0,          64'd0,                           1, 0};
    tbl[5]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          0, 1};
    tbl[6]  = '{1, 32'h8000_0000,  32'd2,          {32'd0, 32'hC000_0000},          0, 0};
    tbl[7]  = '{1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          0, 0};
    tbl[8]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1},                  0, 0};
    tbl[9]  = '{0, 32'd5,          32'd9,          {32'd5, 32'd0},                  0, 0};
    tbl[10] = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3},          0, 0};

    rst = 1'b0; sgn = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
    #2;
    chk("reset outputs", 64'(all_out_zero()), 64'd1);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i]) run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].rq, tbl[i].dz, tbl[i].ovf,
                            $sformatf("vec%0d", i));

    // annul mid-iteration: no ready pulse from any width
    @(negedge clk); sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(negedge clk); annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; for (int d = 0; d < 3; d++) if (rdy[d] !== 1'b0) seen = 1'b1; end
    chk("annul busy no ready", 64'(seen), 64'd0);
    run_op(0, 32'd50, 32'd5, {32'd0, 32'd10}, 0, 0, "after annul");

    // start together with annul in idle must be ignored (zero divisor would otherwise answer in 1)
    @(negedge clk); op2 = 32'd0; start = 1'b1; annul = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; for (int d = 0; d < 3; d++) if (rdy[d] !== 1'b0) seen = 1'b1; end
    @(negedge clk); start = 1'b0; annul = 1'b0;
    chk("annul idle ignored", 64'(seen), 64'd0);

    // async reset while holding a finished result
    @(negedge clk); sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ready before reset", 64'({rdy[0], rdy[1], rdy[2]}), 64'b111);
    #1; rst = 1'b0;
    #1;
    chk("async reset in done", 64'(all_out_zero()), 64'd1);
    @(negedge clk); start = 1'b0; rst = 1'b1;

    // async reset mid-iteration, then a clean operation
    @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; start = 1'b0;
    #1;
    chk("async reset in busy", 64'(all_out_zero()), 64'd1);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; for (int d = 0; d < 3; d++) if (rdy[d] !== 1'b0) seen = 1'b1; end
    chk("no ready after busy reset", 64'(seen), 64'd0);
    run_op(0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 0, "after reset");

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(s, a, b, erq, edz, eovf);
      run_op(s, a, b, erq, edz, eovf, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
